bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq_if.sv | 32 +++
 rtl/bin_to_bcd_seq.sv | 101 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq_if
//  Description : Request/result bundle for the sequential binary-to-BCD
//                converter. The master issues start/bin; the converter
//                (slave) returns busy, done and the packed BCD result.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bin_to_bcd_seq_if;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd
    );
endinterface
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Iterative shift-add-3 (double-dabble) converter, 8-bit
//                unsigned binary to 3-digit packed BCD. One bit per cycle,
//                result and a one-cycle done pulse 8 cycles after acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq (
    input  wire logic         clk,
    input  wire logic         rst,
    bin_to_bcd_seq_if.slave   bus
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]  state;
    logic [0:0]  state_next;
    logic [7:0]  shift_reg;
    logic [11:0] scratch;
    logic [2:0]  count;
    logic [11:0] bcd_reg;
    logic        done_reg;

    logic [11:0] adjusted;
    logic [11:0] scratch_next;
    logic [7:0]  shift_next;
    logic        last_step;

    // Add-3 correction on the pre-shift nibbles, then one-bit left shift.
    always_comb begin
        adjusted[11:8] = (scratch[11:8] >= 4'd5) ? scratch[11:8] + 4'd3 : scratch[11:8];
        adjusted[7:4]  = (scratch[7:4]  >= 4'd5) ? scratch[7:4]  + 4'd3 : scratch[7:4];
        adjusted[3:0]  = (scratch[3:0]  >= 4'd5) ? scratch[3:0]  + 4'd3 : scratch[3:0];
        // The top adjusted bit is always shifted out; it is zero for 8-bit operands.
        scratch_next   = 12'({adjusted, shift_reg[7]});
        shift_next     = {shift_reg[6:0], 1'b0};
        last_step      = (count == 3'd7);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept start only when idle, leave SHIFT after the 8th bit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: busy follows the state, done/bcd come from registers.
    always_comb begin
        bus.busy = (state == SHIFT);
        bus.done = done_reg;
        bus.bcd  = bcd_reg;
    end

    // Datapath: operand capture, per-bit conversion step and result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= 8'd0;
            scratch   <= 12'd0;
            count     <= 3'd0;
            bcd_reg   <= 12'd0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift_reg <= bus.bin;
                        scratch   <= 12'd0;
                        count     <= 3'd0;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_next;
                    scratch   <= scratch_next;
                    count     <= count + 3'd1;
                    if (last_step) begin
                        bcd_reg  <= scratch_next;
                        done_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_bcd_seq
//  Description : Self-checking bench for bin_to_bcd_seq. Expected results
//                come from decimal arithmetic on the operand.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    bin_to_bcd_seq_if bus_if ();

    bin_to_bcd_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // One-cycle start pulse, then scramble bin and follow the conversion.
    task automatic convert(input logic [7:0] v, input string tag);
        int lat;
        int busy_cnt;
        bus_if.start = 1'b1;
        bus_if.bin   = v;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.bin   = 8'($urandom);
        lat      = 1;
        busy_cnt = 0;
        while (!bus_if.done && lat < 40) begin
            if (bus_if.busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 9);
        check({tag, "_busy_cycles"}, busy_cnt, 8);
        check({tag, "_bcd"}, bus_if.bcd, ref_bcd(int'(v)));
        check({tag, "_busy_at_done"}, bus_if.busy, 1'b0);
        @(negedge clk);
        check({tag, "_done_single"}, bus_if.done, 1'b0);
        check({tag, "_bcd_hold"}, bus_if.bcd, ref_bcd(int'(v)));
    endtask

    initial begin
        int dones;
        logic [11:0] seen;
        int cnt;
        logic [11:0] r;
        logic [7:0] vals [5];

        bus_if.start = 1'b0;
        bus_if.bin   = 8'd0;

        // Reset for two cycles.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", bus_if.busy, 1'b0);
        check("reset_done", bus_if.done, 1'b0);
        check("reset_bcd",  bus_if.bcd, 12'h000);

        // Maximum operand.
        convert(8'd255, "max255");

        // Digit-boundary operands.
        vals = '{8'd0, 8'd9, 8'd99, 8'd100, 8'd200};
        foreach (vals[i]) convert(vals[i], "boundary");

        // Start while busy is ignored; bin changes mid-conversion are ignored.
        bus_if.start = 1'b1;
        bus_if.bin   = 8'd137;
        @(negedge clk);
        bus_if.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.bin   = 8'd42;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.bin   = 8'd77;
        dones = 0;
        seen  = 12'h0;
        for (int i = 0; i < 30; i++) begin
            if (bus_if.done) begin
                dones++;
                seen = bus_if.bcd;
            end
            @(negedge clk);
        end
        check("ignore_done_count", dones, 1);
        check("ignore_bcd", seen, 12'h137);
        check("ignore_idle_after", bus_if.busy, 1'b0);

        // Reset aborts an in-progress conversion.
        bus_if.start = 1'b1;
        bus_if.bin   = 8'd200;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", bus_if.busy, 1'b0);
        check("abort_bcd", bus_if.bcd, 12'h000);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus_if.done) dones++;
            @(negedge clk);
        end
        check("abort_no_done", dones, 0);
        check("abort_bcd_held", bus_if.bcd, 12'h000);
        convert(8'd58, "after_reset58");

        // Random operands.
        for (int i = 0; i < 20; i++) convert(8'($urandom_range(0, 255)), "random");

        // Exhaustive sweep with start held high: one result every 9 cycles.
        bus_if.start = 1'b1;
        bus_if.bin   = 8'd0;
        for (int v = 0; v < 256; v++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!bus_if.done && cnt < 40);
            r = bus_if.bcd;
            check("sweep_bcd", r, ref_bcd(v));
            check("sweep_gap", cnt, 9);
            check("sweep_nibbles", (r[11:8] <= 4'd2) && (r[7:4] <= 4'd9) && (r[3:0] <= 4'd9), 1'b1);
            bus_if.bin = 8'(v + 1);
            if (v == 255) bus_if.start = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("sweep_end_idle", bus_if.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
